// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Package  : trace_pkg
// Purpose  : Shared types and constants for the PC-trace capture buffer.
//            Holds the capture state encoding, the trace entry width and a
//            saturating increment helper for the overwrite (drop) counter.
// Contents : TRACE_W        - width of one trace entry {perf, pc}
//            trace_state_t  - IDLE/CAPTURE/POST/FROZEN (2-bit encoding)
//            sat_inc16()    - 16-bit increment that sticks at 0xFFFF
// Revision : 1.0 - initial release
// ============================================================================
package trace_pkg;

   localparam int TRACE_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_POST    = 2'd2,
      ST_FROZEN  = 2'd3
   } trace_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_trace_buf_if.sv
`default_nettype none
// ============================================================================
// Interface : pc_trace_buf_if
// Purpose   : Valid/ready readout stream from the trace buffer to the
//             online-debug host.
// Signals   : tvalid - entry valid (driven by buffer)
//             tready - host accepts entry (driven by host)
//             tdata  - {perf[31:0], pc[31:0]}
//             tlast  - current entry is the final one of the frozen history
// Modports  : master - buffer side, slave - host side
// Revision  : 1.0 - initial release
// ============================================================================
interface pc_trace_buf_if;
   import trace_pkg::*;

   logic               tvalid;
   logic               tready;
   logic [TRACE_W-1:0] tdata;
   logic               tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface
`default_nettype wire

// File: rtl/trace_ram.sv
`default_nettype none
// ============================================================================
// Module   : trace_ram
// Purpose  : DEPTH x WIDTH simple dual-port storage for the trace ring.
//            Synchronous write, asynchronous read, no reset on the array so
//            it maps onto distributed RAM.
// Ports    : clk     - write clock
//            i_we    - write enable
//            i_waddr - write address
//            i_wdata - write data
//            i_raddr - read address
//            o_rdata - read data (combinational from i_raddr)
// Revision : 1.0 - initial release
// ============================================================================
module trace_ram #(
   parameter  int DEPTH = 64,
   parameter  int WIDTH = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  wire              clk,
   input  wire              i_we,
   input  wire  [AW-1:0]    i_waddr,
   input  wire  [WIDTH-1:0] i_wdata,
   input  wire  [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/pc_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : pc_trace_buf
// Purpose  : Circular PC-trace capture buffer. Records {perf, pc} for every
//            retired instruction into a ring of the last DEPTH entries. On an
//            error it captures POST_ERR further entries, freezes, and then
//            streams the frozen history out oldest-first.
// Params   : DEPTH    - ring entries (power of two, >= 4)
//            POST_ERR - entries captured after the error cycle (0..DEPTH-1)
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_arm         - start capture (honoured in IDLE only)
//            i_clear       - abort to IDLE, empty buffer, zero drop count
//            i_pc          - retired instruction PC
//            i_pc_valid    - i_pc/i_perf valid this cycle
//            i_perf        - cycle counter timestamp
//            i_error       - core error flag (level)
//            o_trace       - readout stream (tvalid/tready/tdata/tlast)
//            o_state       - IDLE=0, CAPTURE=1, POST=2, FROZEN=3
//            o_count       - entries held
//            o_drop        - entries overwritten since arm (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module pc_trace_buf
   import trace_pkg::*;
#(
   parameter int DEPTH    = 64,
   parameter int POST_ERR = 8
) (
   input  wire                     clk,
   input  wire                     rst,
   input  wire                     i_arm,
   input  wire                     i_clear,
   input  wire  [31:0]             i_pc,
   input  wire                     i_pc_valid,
   input  wire  [31:0]             i_perf,
   input  wire                     i_error,
   pc_trace_buf_if.master          o_trace,
   output logic [1:0]              o_state,
   output logic [$clog2(DEPTH):0]  o_count,
   output logic [15:0]             o_drop
);

   localparam int            AW          = $clog2(DEPTH);
   localparam logic [AW:0]   c_FULL      = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] c_POST_INIT = AW'(POST_ERR);
   localparam bit            c_NO_POST   = (POST_ERR == 0);

   trace_state_t       r_state;
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [AW-1:0]      r_post_cnt;
   logic [AW:0]        r_count;
   logic [15:0]        r_drop;

   logic               w_capturing;
   logic               w_wr_en;
   logic               w_full;
   logic               w_tvalid;
   logic               w_hs;
   logic [TRACE_W-1:0] w_rd_data;

   assign w_capturing = (r_state == ST_CAPTURE) || (r_state == ST_POST);
   // Clear/reset win over a write in the same cycle, so the array never
   // sees a write the pointer logic did not account for.
   assign w_wr_en     = w_capturing && i_pc_valid && !i_clear && !rst;
   assign w_full      = (r_count == c_FULL);
   assign w_tvalid    = (r_state == ST_FROZEN) && (r_count != '0);
   assign w_hs        = w_tvalid && o_trace.tready;

   trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (TRACE_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_wr_en),
      .i_waddr (r_wr_ptr),
      .i_wdata ({i_perf, i_pc}),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_state    <= ST_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_post_cnt <= '0;
         r_count    <= '0;
         r_drop     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // Array contents are left alone; only bookkeeping restarts.
               if (i_arm) begin
                  r_state    <= ST_CAPTURE;
                  r_wr_ptr   <= '0;
                  r_rd_ptr   <= '0;
                  r_post_cnt <= '0;
                  r_count    <= '0;
                  r_drop     <= '0;
               end
            end

            ST_CAPTURE, ST_POST: begin
               if (i_pc_valid) begin
                  r_wr_ptr <= r_wr_ptr + 1'b1;
                  if (w_full) begin
                     // Ring full: the write lands on the oldest slot, so the
                     // read pointer steps past it and the count holds.
                     r_rd_ptr <= r_rd_ptr + 1'b1;
                     r_drop   <= sat_inc16(r_drop);
                  end else begin
                     r_count <= r_count + 1'b1;
                  end
               end

               if (r_state == ST_CAPTURE) begin
                  // The error-cycle write is stored but is not one of the
                  // post-error entries.
                  if (i_error) begin
                     if (c_NO_POST) begin
                        r_state <= ST_FROZEN;
                     end else begin
                        r_state    <= ST_POST;
                        r_post_cnt <= c_POST_INIT;
                     end
                  end
               end else if (i_pc_valid) begin
                  r_post_cnt <= r_post_cnt - 1'b1;
                  if (r_post_cnt == AW'(1)) begin
                     r_state <= ST_FROZEN;
                  end
               end
            end

            ST_FROZEN: begin
               if (r_count == '0) begin
                  r_state <= ST_IDLE;
               end else if (w_hs) begin
                  r_rd_ptr <= r_rd_ptr + 1'b1;
                  r_count  <= r_count - 1'b1;
                  if (r_count == (AW+1)'(1)) begin
                     r_state <= ST_IDLE;
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_trace.tvalid = w_tvalid;
   assign o_trace.tdata  = w_tvalid ? w_rd_data : '0;
   assign o_trace.tlast  = w_tvalid && (r_count == (AW+1)'(1));

   assign o_state = r_state;
   assign o_count = r_count;
   assign o_drop  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_pc_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_trace_buf
// Purpose  : Self-checking bench for pc_trace_buf. Two instances share the
//            same stimulus: A (DEPTH=8, POST_ERR=2) and B (DEPTH=4,
//            POST_ERR=0). Each is compared every cycle against a queue-based
//            reference model, plus directed checks for the named scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_trace_buf;
   import trace_pkg::*;

   localparam int DA = 8;
   localparam int PA = 2;
   localparam int DB = 4;
   localparam int PB = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, i_arm, i_clear, i_pc_valid, i_error, tready;
   logic [31:0] i_pc, i_perf;

   logic [1:0]           st_a, st_b;
   logic [$clog2(DA):0]  cnt_a;
   logic [$clog2(DB):0]  cnt_b;
   logic [15:0]          drop_a, drop_b;

   pc_trace_buf_if if_a ();
   pc_trace_buf_if if_b ();
   assign if_a.tready = tready;
   assign if_b.tready = tready;

   pc_trace_buf #(.DEPTH(DA), .POST_ERR(PA)) dut_a (
      .clk(clk), .rst(rst), .i_arm(i_arm), .i_clear(i_clear),
      .i_pc(i_pc), .i_pc_valid(i_pc_valid), .i_perf(i_perf), .i_error(i_error),
      .o_trace(if_a), .o_state(st_a), .o_count(cnt_a), .o_drop(drop_a)
   );

   pc_trace_buf #(.DEPTH(DB), .POST_ERR(PB)) dut_b (
      .clk(clk), .rst(rst), .i_arm(i_arm), .i_clear(i_clear),
      .i_pc(i_pc), .i_pc_valid(i_pc_valid), .i_perf(i_perf), .i_error(i_error),
      .o_trace(if_b), .o_state(st_b), .o_count(cnt_b), .o_drop(drop_b)
   );

   // Reference model: history as a plain queue, oldest at the front.
   logic [63:0] mq [2][$];
   int          ms    [2];
   int          mdrop [2];
   int          mpost [2];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_step(int k);
      int d;
      int p;
      d = (k == 0) ? DA : DB;
      p = (k == 0) ? PA : PB;
      if (rst || i_clear) begin
         mq[k].delete();
         ms[k]    = 0;
         mdrop[k] = 0;
         mpost[k] = 0;
         return;
      end
      case (ms[k])
         0: begin
            if (i_arm) begin
               mq[k].delete();
               mdrop[k] = 0;
               ms[k]    = 1;
            end
         end
         1, 2: begin
            if (i_pc_valid) begin
               mq[k].push_back({i_perf, i_pc});
               if (mq[k].size() > d) begin
                  void'(mq[k].pop_front());
                  if (mdrop[k] < 65535) mdrop[k]++;
               end
            end
            if (ms[k] == 1) begin
               if (i_error) begin
                  if (p == 0) ms[k] = 3;
                  else begin
                     ms[k]    = 2;
                     mpost[k] = p;
                  end
               end
            end else if (i_pc_valid) begin
               mpost[k]--;
               if (mpost[k] == 0) ms[k] = 3;
            end
         end
         default: begin
            if (mq[k].size() == 0) ms[k] = 0;
            else if (tready) begin
               void'(mq[k].pop_front());
               if (mq[k].size() == 0) ms[k] = 0;
            end
         end
      endcase
   endtask

   task automatic check_inst(int k, logic [1:0] st, logic [15:0] cnt, logic [15:0] drp,
                             logic tv, logic [63:0] td, logic tl);
      string p;
      bit    ev;
      p  = (k == 0) ? "a" : "b";
      ev = (ms[k] == 3) && (mq[k].size() != 0);
      chk({p, "_state"},  64'(st),  64'(ms[k]));
      chk({p, "_count"},  64'(cnt), 64'(mq[k].size()));
      chk({p, "_drop"},   64'(drp), 64'(mdrop[k]));
      chk({p, "_tvalid"}, 64'(tv),  64'(ev));
      chk({p, "_tdata"},  td,       ev ? mq[k][0] : 64'd0);
      chk({p, "_tlast"},  64'(tl),  64'(ev && (mq[k].size() == 1)));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_inst(0, st_a, 16'(cnt_a), drop_a, if_a.tvalid, if_a.tdata, if_a.tlast);
      check_inst(1, st_b, 16'(cnt_b), drop_b, if_b.tvalid, if_b.tdata, if_b.tlast);
   endtask

   task automatic idle_in();
      rst = 1'b0; i_arm = 1'b0; i_clear = 1'b0; i_pc_valid = 1'b0;
      i_error = 1'b0; tready = 1'b0; i_pc = '0; i_perf = '0;
   endtask

   task automatic retire(logic [31:0] pc, logic [31:0] perf, logic err);
      i_pc = pc; i_perf = perf; i_pc_valid = 1'b1; i_error = err;
      tick();
      i_pc_valid = 1'b0; i_error = 1'b0;
   endtask

   task automatic clear_arm();
      i_clear = 1'b1; tick(); i_clear = 1'b0;
      i_arm   = 1'b1; tick(); i_arm   = 1'b0;
   endtask

   logic [31:0] last_pc;
   logic [31:0] got_b [$];

   initial begin
      for (int k = 0; k < 2; k++) begin
         ms[k] = 0; mdrop[k] = 0; mpost[k] = 0;
      end
      idle_in();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      chk("rst_state", 64'(st_a), 64'd0);
      chk("rst_tdata", if_a.tdata, 64'd0);

      // Scenario 1: five retires, error on the fifth, two post-error retires.
      clear_arm();
      for (int i = 0; i < 5; i++) retire(32'h100 + 32'(4*i), 32'(10+i), (i == 4));
      retire(32'h114, 32'd15, 1'b1);   // error while in POST must be ignored
      retire(32'h118, 32'd16, 1'b0);
      chk("p1_state",      64'(st_a),            64'd3);
      chk("p1_count",      64'(cnt_a),           64'd7);
      chk("p1_first_pc",   64'(if_a.tdata[31:0]),  64'h100);
      chk("p1_first_perf", 64'(if_a.tdata[63:32]), 64'd10);
      i_pc_valid = 1'b1; i_pc = 32'hDEAD; tick(); tick(); i_pc_valid = 1'b0;
      chk("p1_frozen_count", 64'(cnt_a), 64'd7);
      tready  = 1'b1;
      last_pc = '0;
      for (int n = 0; n < 20 && st_a != 2'd0; n++) begin
         if (if_a.tvalid && if_a.tlast) last_pc = if_a.tdata[31:0];
         tick();
      end
      tready = 1'b0;
      chk("p1_last_pc", 64'(last_pc), 64'h118);
      chk("p1_idle",    64'(st_a),    64'd0);

      // Scenario 2: DEPTH=4 instance overflows, readout with stalls.
      clear_arm();
      for (int i = 0; i < 10; i++) retire(32'(4*i), 32'(100+i), (i == 9));
      chk("p2_count", 64'(cnt_b),  64'd4);
      chk("p2_drop",  64'(drop_b), 64'd6);
      chk("p2_state", 64'(st_b),   64'd3);
      got_b.delete();
      for (int i = 0; i < 12 && st_b != 2'd0; i++) begin
         tready = ((i % 4) == 0) || ((i % 4) == 3);
         if (if_b.tvalid && tready) got_b.push_back(if_b.tdata[31:0]);
         tick();
      end
      tready = 1'b0;
      chk("p2_n_read", 64'(got_b.size()), 64'd4);
      for (int j = 0; j < 4; j++) begin
         if (j < got_b.size()) chk("p2_read_pc", 64'(got_b[j]), 64'h18 + 64'(4*j));
      end

      // Scenario 3: clear on the second handshake, then arm+clear together.
      clear_arm();
      retire(32'h200, 32'd1, 1'b0);
      retire(32'h204, 32'd2, 1'b0);
      retire(32'h208, 32'd3, 1'b1);
      retire(32'h20C, 32'd4, 1'b0);
      retire(32'h210, 32'd5, 1'b0);
      tready = 1'b1; tick();
      i_clear = 1'b1; tick(); i_clear = 1'b0; tready = 1'b0;
      chk("p3_tvalid", 64'(if_a.tvalid), 64'd0);
      chk("p3_count",  64'(cnt_a),       64'd0);
      i_arm = 1'b1; i_clear = 1'b1; tick(); i_arm = 1'b0; i_clear = 1'b0;
      chk("p3_arm_clear", 64'(st_a), 64'd0);

      // Scenario 4: reset in the middle of POST, then a clean re-arm.
      clear_arm();
      retire(32'h300, 32'd7, 1'b1);
      retire(32'h304, 32'd8, 1'b0);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("p4_state",  64'(st_a),        64'd0);
      chk("p4_count",  64'(cnt_a),       64'd0);
      chk("p4_tvalid", 64'(if_a.tvalid), 64'd0);
      i_arm = 1'b1; tick(); i_arm = 1'b0;
      chk("p4_rearm_state", 64'(st_a),  64'd1);
      chk("p4_rearm_count", 64'(cnt_a), 64'd0);
      retire(32'h400, 32'd9, 1'b0);
      chk("p4_count1", 64'(cnt_a), 64'd1);

      // Randomised traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         rst        = ($urandom_range(0, 255) == 0);
         i_clear    = ($urandom_range(0, 63) == 0);
         i_arm      = ($urandom_range(0, 7) == 0);
         i_pc_valid = 1'($urandom_range(0, 1));
         i_error    = ($urandom_range(0, 15) == 0);
         tready     = 1'($urandom_range(0, 1));
         i_pc       = $urandom;
         i_perf     = $urandom;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_trace_buf.md
# pc_trace_buf

Circular PC-trace capture buffer downstream of the core's retire/debug outputs. It records `{perf, pc}` for every retired instruction into a ring of the last DEPTH entries. On `error` it captures POST_ERR more entries and then freezes. It streams the frozen history out oldest-first over a valid/ready port for the online-debug host.

## Interface
Parameters:
- DEPTH, 64, ring entries; power of two, ≥4
- POST_ERR, 8, entries captured after the error cycle before freezing; 0..DEPTH-1

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- i_arm  in  1  pulse: start capture (honoured in IDLE only)
- i_clear  in  1  pulse: abort to IDLE, empty buffer, zero drop count
- i_pc  in  32  retired instruction PC
- i_pc_valid  in  1  i_pc/i_perf valid this cycle
- i_perf  in  32  cycle counter timestamp
- i_error  in  1  core error flag (level)
- o_tvalid  out  1  readout entry valid
- i_tready  in  1  host accepts entry
- o_tdata  out  64  {perf[31:0], pc[31:0]}
- o_tlast  out  1  current entry is the final one
- o_state  out  2  IDLE=0, CAPTURE=1, POST=2, FROZEN=3
- o_count  out  $clog2(DEPTH)+1  entries held
- o_drop  out  16  entries overwritten since arm; saturates at 0xFFFF

## Operation
- IDLE: no writes. o_tvalid=0. i_arm → CAPTURE.
- CAPTURE: each i_pc_valid cycle writes `{i_perf,i_pc}` at wr_ptr.
  - Not full: count+1.
  - Full: oldest entry overwritten, rd_ptr advances, count stays DEPTH, o_drop+1 (saturating).
  - i_error=1 → POST, post_cnt=POST_ERR. An entry written in the error cycle is stored but does not decrement post_cnt. If POST_ERR=0 → FROZEN directly.
- POST: writes as in CAPTURE. Each write decrements post_cnt; the write taking it to 0 → FROZEN. Further i_error is ignored.
- FROZEN: no writes; i_pc_valid is ignored.
  - o_tvalid = (count≠0); o_tdata = mem[rd_ptr]; o_tlast = (count==1).
  - Handshake (o_tvalid & i_tready): rd_ptr+1, count-1.
  - The handshake with o_tlast=1 → IDLE.
  - FROZEN with count=0 on entry → IDLE next cycle.
- i_clear: in any state → IDLE, pointers=0, count=0, o_drop=0, post_cnt=0. Clear beats i_arm in the same cycle.
- i_arm outside IDLE: ignored. Entering CAPTURE does not clear the contents of an IDLE buffer; pointers and count reset to 0 and o_drop=0 on arm.
- Pointers are $clog2(DEPTH) bits and wrap naturally.

## Timing
- Reset values: o_state=0, o_count=0, o_drop=0, o_tvalid=0, o_tlast=0, o_tdata=0 (mem contents undefined; output gated to 0 when !o_tvalid).
- Capture latency: sample at edge N; entry visible in o_count after edge N.
- State transitions are registered; arm at edge N → writes accepted from cycle N+1.
- The FROZEN transition is registered; o_tvalid can first assert the cycle after entering FROZEN.
- Readout: o_tdata/o_tlast combinational from registered rd_ptr/count. One entry per cycle at i_tready=1.
- o_tvalid, once high, stays high with stable data until accepted, except under i_clear/rst.
- Reset or i_clear mid-readout drops remaining entries; o_tvalid=0 next cycle.

## Structure
- Shared package `trace_pkg`: state enum (IDLE/CAPTURE/POST/FROZEN, 2 bits) and TRACE_W=64 entry width constant.
- Sub-module `trace_ram`: DEPTH×64 simple dual-port array, synchronous write, asynchronous read; inferable as distributed RAM.
- Top holds the FSM, pointers, count, post_cnt and drop counter.

## Test plan
- Arm, 5 retires (pc 0x100..0x110, perf 10..14), error on the 5th, POST_ERR=2, 2 more retires → FROZEN, count=7. Readout gives pc 0x100 first, 0x118 last with o_tlast; then IDLE.
- DEPTH=4: arm, 10 retires pc 0x0..0x24 step 4, error on the last, POST_ERR=0 → count=4, o_drop=6. Readout pc 0x18,0x1C,0x20,0x24.
- FROZEN readout with i_tready toggling 1,0,0,1: o_tdata holds stable while stalled; no entry is lost or duplicated.
- i_pc_valid pulses during FROZEN and i_error during POST → no effect on count or post_cnt.
- i_clear in the cycle of the 2nd handshake → o_tvalid=0 and count=0 next cycle; simultaneous i_arm+i_clear stays IDLE.
- rst asserted mid-POST → all outputs at reset values next cycle; a following arm restarts cleanly with count=0.
